mult: RTL and testbench

Sequential signed 32×32 multiplier for the processor datapath. It is the inverse-operation companion of the iterative divider and shares the divider's Hi/Lo result convention and its start/end handshake. It uses radix-2 Booth's algorithm and returns a 64-bit product split across `Hi`/`Lo` in a fixed 32 steps. The control unit pulses `MultControl`, waits for `MultEnd`, then moves `Hi`/`Lo` into the register bank.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/booth_step.sv | 36 +++
 rtl/mult.sv | 80 ++++++++
 tb/tb_mult.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing constants for the sequential Booth multiplier.
// The counter width derives from the step count so that the full count fits.
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_STEPS = MULT_WIDTH;

  // Bits needed to hold the values 0..steps inclusive.
  function automatic int cnt_width(input int steps);
    return $clog2(steps + 1);
  endfunction

  localparam int MULT_CNT_W = cnt_width(MULT_STEPS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mult_state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract the multiplicand into the accumulator,
// then arithmetic-shift {acc, q, q_1} right by one. Purely combinational.
module booth_step #(
  parameter int W = 32
) (
  input  logic [W:0]   acc,
  input  logic [W-1:0] q,
  input  logic         q_1,
  input  logic [W:0]   m,
  output logic [W:0]   acc_next,
  output logic [W-1:0] q_next,
  output logic         q_1_next
);

  logic [W:0] sum;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sum      = acc;
    acc_next = '0;
    q_next   = '0;
    q_1_next = 1'b0;

    unique case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase

    // Sign bit replicates from the accumulator MSB; its LSB drops into q.
    acc_next = {sum[W], sum[W:1]};
    q_next   = {sum[0], q[W-1:1]};
    q_1_next = q[0];
  end

endmodule

// File: rtl/mult.sv
// Sequential signed WIDTH x WIDTH multiplier (radix-2 Booth), WIDTH steps per product.
// Start/end handshake and Hi/Lo split match the iterative divider.
module mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic             MultControl,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             MultEnd
);

  localparam int CNT_W = cnt_width(WIDTH);

  mult_state_t      state;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [WIDTH:0]   m;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   acc_n;
  logic [WIDTH-1:0] q_n;
  logic             q_1_n;

  booth_step #(.W(WIDTH)) u_step (
    .acc      (acc),
    .q        (q),
    .q_1      (q_1),
    .m        (m),
    .acc_next (acc_n),
    .q_next   (q_n),
    .q_1_next (q_1_n)
  );

  // Priority: reset, then start (restarts from any state), then a Booth step in RUN.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      state   <= IDLE;
      acc     <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      m       <= '0;
      cnt     <= '0;
      Hi      <= '0;
      Lo      <= '0;
      MultEnd <= 1'b0;
    end else if (MultControl) begin
      state   <= RUN;
      acc     <= '0;
      q       <= InA;
      q_1     <= 1'b0;
      m       <= {InB[WIDTH-1], InB};
      cnt     <= CNT_W'(WIDTH);
      MultEnd <= 1'b0;
    end else begin
      MultEnd <= 1'b0;
      if (state == RUN) begin
        acc <= acc_n;
        q   <= q_n;
        q_1 <= q_1_n;
        cnt <= cnt - 1'b1;
        // Last step: publish the product straight from the step outputs.
        if (cnt == CNT_W'(1)) begin
          Hi      <= acc_n[WIDTH-1:0];
          Lo      <= q_n;
          MultEnd <= 1'b1;
          state   <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for mult: directed product table, multi-cycle corner sequences,
// and back-to-back random products against a 64-bit signed reference.
module tb_mult;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InA, InB;
  logic        MultControl;
  logic [31:0] Hi, Lo;
  logic        MultEnd;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .InA         (InA),
    .InB         (InB),
    .MultControl (MultControl),
    .Hi          (Hi),
    .Lo          (Lo),
    .MultEnd     (MultEnd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  // Returns after the start edge has been sampled.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    InA = a;
    InB = b;
    MultControl = 1'b1;
    @(negedge clk);
    MultControl = 1'b0;
  endtask

  // Counts edges since the start edge until MultEnd; checks latency and Hi/Lo hold.
  task automatic wait_done(input string tag, output int n);
    logic held_ok;
    held_ok = 1'b1;
    n = 0;
    while (!MultEnd && n < 40) begin
      if (Hi !== exp_hi || Lo !== exp_lo) held_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "_hold"}, 64'(held_ok), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'd32);
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  vec_t vecs[9];

  initial begin
    int n;
    logic seen;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[4] = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
    vecs[5] = '{32'h00000001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[6] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001};
    vecs[8] = '{32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

    // Reset state.
    reset = 1'b0; MultControl = 1'b0; InA = '0; InB = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", 64'(Hi), 64'd0);
    check("reset_lo", 64'(Lo), 64'd0);
    check("reset_end", 64'(MultEnd), 64'd0);
    reset = 1'b1;

    // Directed table; operands are scrambled after the start edge.
    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      InA = 32'hDEADBEEF;
      InB = 32'hCAFEF00D;
      wait_done($sformatf("vec%0d", i), n);
      check($sformatf("vec%0d_prod", i), {Hi, Lo}, {vecs[i].hi, vecs[i].lo});
      exp_hi = vecs[i].hi;
      exp_lo = vecs[i].lo;
      @(negedge clk);
      check($sformatf("vec%0d_pulse", i), 64'(MultEnd), 64'd0);
      check($sformatf("vec%0d_keep", i), {Hi, Lo}, {exp_hi, exp_lo});
    end

    // Restart mid-run: only the second operation completes.
    start_op(32'd5, 32'd5);
    repeat (9) @(negedge clk);
    start_op(32'd3, 32'd4);
    wait_done("restart", n);
    check("restart_prod", {Hi, Lo}, 64'd12);
    exp_hi = 32'd0; exp_lo = 32'd12;

    // Start at E32: restart wins, no completion, Hi/Lo untouched.
    start_op(32'd9, 32'd9);
    repeat (30) @(negedge clk);
    start_op(32'd2, 32'd3);
    check("e32_no_end", 64'(MultEnd), 64'd0);
    check("e32_keep", {Hi, Lo}, {exp_hi, exp_lo});
    wait_done("e32", n);
    check("e32_prod", {Hi, Lo}, 64'd6);
    exp_hi = 32'd0; exp_lo = 32'd6;

    // Start held high: never completes; completes 32 edges after release.
    @(negedge clk);
    InA = 32'hFFFFFFFE; InB = 32'd50; MultControl = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (MultEnd) seen = 1'b1;
    end
    check("held_no_end", 64'(seen), 64'd0);
    MultControl = 1'b0;
    wait_done("held", n);
    check("held_prod", {Hi, Lo}, 64'hFFFFFFFF_FFFFFF9C);
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFF9C;

    // Reset mid-run: aborts, zeroes outputs, no MultEnd afterwards.
    start_op(32'd6, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rstrun_hi", 64'(Hi), 64'd0);
    check("rstrun_lo", 64'(Lo), 64'd0);
    check("rstrun_end", 64'(MultEnd), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (MultEnd) seen = 1'b1;
    end
    check("rstrun_no_end", 64'(seen), 64'd0);
    exp_hi = '0; exp_lo = '0;

    // Random products, each next start sampled at the E33 edge.
    ra = $urandom; rb = $urandom;
    start_op(ra, rb);
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] want;
      want = ref_prod(ra, rb);
      wait_done($sformatf("rnd%0d", i), n);
      check($sformatf("rnd%0d_prod a=%0h b=%0h", i, ra, rb), {Hi, Lo}, want);
      exp_hi = want[63:32];
      exp_lo = want[31:0];
      if (i < 999) begin
        ra = $urandom; rb = $urandom;
        InA = ra; InB = rb; MultControl = 1'b1;
      end
      @(negedge clk);
      MultControl = 1'b0;
      check($sformatf("rnd%0d_pulse", i), 64'(MultEnd), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
